// File: rtl/trap_sequencer_if.sv
// Trap request, fetch redirect, CSR-instruction and CSR-file port bundle for trap_sequencer.
// slave = sequencer side, master = execute stage / CSR file side.
interface trap_sequencer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 2
);
   logic                  trap_req;
   logic                  trap_kind;
   logic [DATA_WIDTH-1:0] trap_pc;
   logic [DATA_WIDTH-1:0] trap_cause;
   logic                  trap_ack;
   logic                  busy;
   logic                  redirect_vld;
   logic [DATA_WIDTH-1:0] redirect_pc;
   logic [ADDR_WIDTH-1:0] inst_csr_raddr;
   logic                  inst_csr_wen;
   logic [ADDR_WIDTH-1:0] inst_csr_waddr;
   logic [DATA_WIDTH-1:0] inst_csr_wdata;
   logic                  inst_csr_gnt;
   logic [DATA_WIDTH-1:0] csrf_rdata;
   logic [ADDR_WIDTH-1:0] csrf_raddr;
   logic [ADDR_WIDTH-1:0] csrf_waddr;
   logic [DATA_WIDTH-1:0] csrf_wdata;
   logic                  csrf_wen;

   modport slave (
      input  trap_req, trap_kind, trap_pc, trap_cause,
      input  inst_csr_raddr, inst_csr_wen, inst_csr_waddr, inst_csr_wdata,
      input  csrf_rdata,
      output trap_ack, busy, redirect_vld, redirect_pc, inst_csr_gnt,
      output csrf_raddr, csrf_waddr, csrf_wdata, csrf_wen
   );

   modport master (
      output trap_req, trap_kind, trap_pc, trap_cause,
      output inst_csr_raddr, inst_csr_wen, inst_csr_waddr, inst_csr_wdata,
      output csrf_rdata,
      input  trap_ack, busy, redirect_vld, redirect_pc, inst_csr_gnt,
      input  csrf_raddr, csrf_waddr, csrf_wdata, csrf_wen
   );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer sharing the machine CSR file ports with CSR instructions.
// Define TRAP_SEQ_MSTATUS_EN to add the mstatus MIE/MPIE/MPP update step (W_STATUS).
//
// state    | meaning
// IDLE     | CSR ports granted to instructions unless a trap is requested
// W_EPC    | write mepc <- trapping pc (ecall)
// W_CAUSE  | write mcause <- latched cause (ecall)
// W_STATUS | read-modify-write mstatus (TRAP_SEQ_MSTATUS_EN only)
// RD_TGT   | read mtvec (ecall) or mepc (mret) into redirect_pc
// REDIR    | one-cycle fetch redirect pulse
module trap_sequencer #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 2
) (
   input logic              clk,
   input logic              rst_n,
   trap_sequencer_if.slave  bus
);
   localparam logic [ADDR_WIDTH-1:0] IDX_CAUSE  = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] IDX_STATUS = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] IDX_EPC    = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] IDX_TVEC   = ADDR_WIDTH'(3);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      W_EPC    = 3'd1,
      W_CAUSE  = 3'd2,
`ifdef TRAP_SEQ_MSTATUS_EN
      W_STATUS = 3'd3,
`endif
      RD_TGT   = 3'd4,
      REDIR    = 3'd5
   } state_t;

   state_t                state;
   logic                  kind_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] cause_q;
   logic                  redir_vld_q;
   logic [DATA_WIDTH-1:0] redir_pc_q;

   logic                  gnt;
   logic                  seq_wen;
   logic [ADDR_WIDTH-1:0] seq_waddr;
   logic [ADDR_WIDTH-1:0] seq_raddr;
   logic [DATA_WIDTH-1:0] seq_wdata;
   logic [DATA_WIDTH-1:0] tgt_mask;

`ifdef TRAP_SEQ_MSTATUS_EN
   function automatic logic [DATA_WIDTH-1:0] status_upd(input logic [DATA_WIDTH-1:0] s,
                                                        input logic is_mret);
      logic [DATA_WIDTH-1:0] r;
      r = s;
      if (is_mret) begin
         r[3] = s[7];
         r[7] = 1'b1;
      end else begin
         r[7] = s[3];
         r[3] = 1'b0;
      end
      r[12:11] = 2'b11;
      return r;
   endfunction
`endif

   assign gnt      = (state == IDLE) & ~bus.trap_req;
   // mret targets keep bit 1 (IALIGN=16 safe); ecall uses direct-mode mtvec base only
   assign tgt_mask = kind_q ? DATA_WIDTH'(1) : DATA_WIDTH'(3);

   always_comb begin
      seq_wen   = 1'b0;
      seq_waddr = IDX_CAUSE;
      seq_raddr = IDX_CAUSE;
      seq_wdata = '0;
      case (state)
         W_EPC: begin
            seq_wen   = 1'b1;
            seq_waddr = IDX_EPC;
            seq_wdata = pc_q;
         end
         W_CAUSE: begin
            seq_wen   = 1'b1;
            seq_waddr = IDX_CAUSE;
            seq_wdata = cause_q;
         end
`ifdef TRAP_SEQ_MSTATUS_EN
         W_STATUS: begin
            seq_raddr = IDX_STATUS;
            seq_wen   = 1'b1;
            seq_waddr = IDX_STATUS;
            seq_wdata = status_upd(bus.csrf_rdata, kind_q);
         end
`endif
         RD_TGT:  seq_raddr = kind_q ? IDX_EPC : IDX_TVEC;
         default: ;
      endcase
   end

   // Sequencer writes are suppressed while reset is held so an aborted step never commits.
   assign bus.csrf_wen     = gnt ? bus.inst_csr_wen   : (seq_wen & rst_n);
   assign bus.csrf_waddr   = gnt ? bus.inst_csr_waddr : seq_waddr;
   assign bus.csrf_wdata   = gnt ? bus.inst_csr_wdata : seq_wdata;
   assign bus.csrf_raddr   = gnt ? bus.inst_csr_raddr : seq_raddr;
   assign bus.inst_csr_gnt = gnt;
   assign bus.trap_ack     = bus.trap_req & (state == IDLE);
   assign bus.busy         = (state != IDLE);
   assign bus.redirect_vld = redir_vld_q;
   assign bus.redirect_pc  = redir_pc_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         kind_q      <= 1'b0;
         pc_q        <= '0;
         cause_q     <= '0;
         redir_vld_q <= 1'b0;
         redir_pc_q  <= '0;
      end else begin
         redir_vld_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.trap_req) begin
                  kind_q  <= bus.trap_kind;
                  pc_q    <= bus.trap_pc;
                  cause_q <= bus.trap_cause;
`ifdef TRAP_SEQ_MSTATUS_EN
                  state   <= bus.trap_kind ? W_STATUS : W_EPC;
`else
                  state   <= bus.trap_kind ? RD_TGT : W_EPC;
`endif
               end
            end
            W_EPC:   state <= W_CAUSE;
`ifdef TRAP_SEQ_MSTATUS_EN
            W_CAUSE:  state <= W_STATUS;
            W_STATUS: state <= RD_TGT;
`else
            W_CAUSE:  state <= RD_TGT;
`endif
            RD_TGT: begin
               redir_pc_q  <= bus.csrf_rdata & ~tgt_mask;
               redir_vld_q <= 1'b1;
               state       <= REDIR;
            end
            REDIR:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
